// File: rtl/hall_emulator.sv
// Hall-sensor emulator: steps through the six 120-degree hall codes at a programmable period.
// Optional fault injection (forced 3'b000 for one step) is enabled by defining HALL_FAULT_INJ_EN.
module hall_emulator #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PERIOD_MIN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic [CNT_W-1:0] period,
    input  logic             fault_req,
    output logic [2:0]       hall_sensors,
    output logic [2:0]       step_idx,
    output logic             step_pulse,
    output logic             rev_pulse,
    output logic             fault_active
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] PMIN = CNT_W'(PERIOD_MIN);

    function automatic logic [2:0] hall_code(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = 3'b001;
            3'd1:    code = 3'b011;
            3'd2:    code = 3'b010;
            3'd3:    code = 3'b110;
            3'd4:    code = 3'b100;
            3'd5:    code = 3'b101;
            default: code = 3'b001;
        endcase
        return code;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             dir_q, dir_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       hall_q, hall_d;
    logic             step_pulse_q, step_pulse_d;
    logic             rev_pulse_q, rev_pulse_d;
    logic             boundary;
    logic             fault_act_d;
    logic [CNT_W-1:0] eff;

    assign eff = (period < PMIN) ? PMIN : period;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        dir_d        = dir_q;
        idx_d        = idx_q;
        step_pulse_d = 1'b0;
        rev_pulse_d  = 1'b0;
        boundary     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d  = RUN;
                    period_d = eff;
                    dir_d    = dir;
                end
            end
            RUN: begin
                // A boundary completes even when en drops on that same cycle.
                if (cnt_q == period_q - 1'b1) begin
                    boundary     = 1'b1;
                    cnt_d        = '0;
                    period_d     = eff;
                    dir_d        = dir;
                    step_pulse_d = 1'b1;
                    if (dir_q) begin
                        if (idx_q == 3'd5) begin
                            idx_d       = 3'd0;
                            rev_pulse_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        if (idx_q == 3'd0) begin
                            idx_d       = 3'd5;
                            rev_pulse_d = 1'b1;
                        end else begin
                            idx_d = idx_q - 3'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        hall_d = fault_act_d ? 3'b000 : hall_code(idx_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            period_q     <= PMIN;
            dir_q        <= 1'b1;
            idx_q        <= 3'd0;
            hall_q       <= 3'b001;
            step_pulse_q <= 1'b0;
            rev_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            dir_q        <= dir_d;
            idx_q        <= idx_d;
            hall_q       <= hall_d;
            step_pulse_q <= step_pulse_d;
            rev_pulse_q  <= rev_pulse_d;
        end
    end

`ifdef HALL_FAULT_INJ_EN
    logic fault_act_q;
    logic fault_pend_q, fault_pend_d;

    // Pending arms on a request; it converts to an active fault at the next boundary.
    always_comb begin
        fault_act_d  = fault_act_q;
        fault_pend_d = fault_pend_q;
        if (state_q == RUN) begin
            if (boundary) begin
                fault_act_d  = fault_pend_q;
                fault_pend_d = 1'b0;
            end
            if (fault_req && !fault_pend_q && !fault_act_q) begin
                fault_pend_d = 1'b1;
            end
            if (!en) begin
                fault_act_d  = 1'b0;
                fault_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_act_q  <= 1'b0;
            fault_pend_q <= 1'b0;
        end else begin
            fault_act_q  <= fault_act_d;
            fault_pend_q <= fault_pend_d;
        end
    end

    assign fault_active = fault_act_q;
`else
    logic unused_fault_req;
    assign unused_fault_req = fault_req;
    assign fault_act_d      = 1'b0;
    assign fault_active     = 1'b0;
`endif

    assign hall_sensors = hall_q;
    assign step_idx     = idx_q;
    assign step_pulse   = step_pulse_q;
    assign rev_pulse    = rev_pulse_q;

endmodule

// File: tb/tb_hall_emulator.sv
// Self-checking bench for hall_emulator: directed literal scenarios plus randomized traffic
// compared every cycle against a step-countdown reference model.
module tb_hall_emulator;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned PMIN  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b1;
    logic             dir = 1'b1;
    logic [CNT_W-1:0] period = 16'd5;
    logic             fault_req = 1'b0;
    logic [2:0]       hall_sensors;
    logic [2:0]       step_idx;
    logic             step_pulse;
    logic             rev_pulse;
    logic             fault_active;

    int n_checks = 0;
    int n_fail   = 0;

    int hall_tbl[6] = '{1, 3, 2, 6, 4, 5};

    hall_emulator #(.CNT_W(CNT_W), .PERIOD_MIN(PMIN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .dir         (dir),
        .period      (period),
        .fault_req   (fault_req),
        .hall_sensors(hall_sensors),
        .step_idx    (step_idx),
        .step_pulse  (step_pulse),
        .rev_pulse   (rev_pulse),
        .fault_active(fault_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: cycles left in the current code, counted down per RUN clock.
    bit          m_run = 0;
    int unsigned m_left = 0;
    int          m_idx = 0;
    bit          m_dir = 1;
    bit          m_sp = 0, m_rp = 0, m_fa = 0, m_pend = 0;

    always @(posedge clk) begin
        int unsigned eff;
        bit req_ok;
        eff = (period < CNT_W'(PMIN)) ? PMIN : int'(period);
        if (!rst_n) begin
            m_run = 0; m_left = 0; m_idx = 0; m_dir = 1;
            m_sp = 0; m_rp = 0; m_fa = 0; m_pend = 0;
        end else if (!m_run) begin
            m_sp = 0; m_rp = 0;
            if (en) begin
                m_run = 1; m_dir = dir; m_left = eff;
            end
        end else begin
            m_sp = 0; m_rp = 0;
            req_ok = fault_req && !m_pend && !m_fa;
            m_left--;
            if (m_left == 0) begin
                m_sp = 1;
                if (m_dir) begin
                    m_rp  = (m_idx == 5);
                    m_idx = (m_idx + 1) % 6;
                end else begin
                    m_rp  = (m_idx == 0);
                    m_idx = (m_idx + 5) % 6;
                end
                m_dir = dir; m_left = eff;
`ifdef HALL_FAULT_INJ_EN
                m_fa = m_pend; m_pend = 0;
`endif
            end
`ifdef HALL_FAULT_INJ_EN
            if (req_ok) m_pend = 1;
`endif
            if (!en) begin
                m_run = 0; m_pend = 0; m_fa = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("model_hall", hall_sensors, m_fa ? 0 : hall_tbl[m_idx]);
        check("model_idx", step_idx, m_idx);
        check("model_step_pulse", step_pulse, m_sp);
        check("model_rev_pulse", rev_pulse, m_rp);
        check("model_fault", fault_active, m_fa);
    end

    task automatic do_reset();
        rst_n = 0; en = 1; fault_req = 0;
        @(negedge clk);
        check("rst_hall", hall_sensors, 1);
        check("rst_idx", step_idx, 0);
        check("rst_pulses", {step_pulse, rev_pulse, fault_active}, 0);
        @(negedge clk);
        check("rst_hall2", hall_sensors, 1);
        check("rst_idx2", step_idx, 0);
        check("rst_pulses2", {step_pulse, rev_pulse, fault_active}, 0);
    endtask

    initial begin
        int e;
        // Forward, period 5: index advances every 5 clocks, wrap after six steps.
        do_reset();
        dir = 1; period = 5; rst_n = 1;
        for (int n = 0; n <= 31; n++) begin
            @(negedge clk);
            e = (n / 5) % 6;
            check("fwd_idx", step_idx, e);
            check("fwd_hall", hall_sensors, hall_tbl[e]);
            check("fwd_step_pulse", step_pulse, (n > 0 && n % 5 == 0));
            check("fwd_rev_pulse", rev_pulse, (n == 30));
        end

        // Reverse from index 0 with period 4: 001 -> 101 -> 100.
        do_reset();
        dir = 0; period = 4; rst_n = 1;
        for (int n = 0; n <= 9; n++) begin
            @(negedge clk);
            e = (n < 4) ? 0 : (n < 8) ? 5 : 4;
            check("rev_idx", step_idx, e);
            check("rev_hall", hall_sensors, hall_tbl[e]);
            check("rev_rev_pulse", rev_pulse, (n == 4));
        end

        // Clamp period 1 to 4; a mid-step change to 10 applies only from the next step.
        do_reset();
        dir = 1; period = 1; rst_n = 1;
        for (int n = 0; n <= 20; n++) begin
            @(negedge clk);
            check("clamp_step_pulse", step_pulse, (n == 4 || n == 8 || n == 18));
            if (n == 6) period = 10;
        end

        // Hold: drop en two clocks into a step, stay frozen, then a full period after re-entry.
        do_reset();
        dir = 1; period = 6; rst_n = 1;
        for (int n = 0; n <= 8; n++) begin
            @(negedge clk);
            check("hold_pre_idx", step_idx, (n < 6) ? 0 : 1);
        end
        en = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("hold_idx", step_idx, 1);
            check("hold_hall", hall_sensors, 3);
            check("hold_pulse", {step_pulse, rev_pulse}, 0);
        end
        en = 1;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            check("reen_idx", step_idx, (k >= 6) ? 2 : 1);
            check("reen_step_pulse", step_pulse, (k == 6));
        end

`ifdef HALL_FAULT_INJ_EN
        // Fault: request early in step 0, step 1 shows 000 for six clocks, then code resumes.
        do_reset();
        dir = 1; period = 6; rst_n = 1;
        for (int n = 0; n <= 14; n++) begin
            @(negedge clk);
            e = n / 6;
            check("flt_idx", step_idx, e);
            check("flt_hall", hall_sensors, (n >= 6 && n < 12) ? 0 : hall_tbl[e]);
            check("flt_active", fault_active, (n >= 6 && n < 12));
            fault_req = (n == 2);
        end
        fault_req = 0;
`endif

        // Randomized traffic checked by the model process.
        do_reset();
        rst_n = 1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 24) == 0) en = ~en;
            if ($urandom_range(0, 14) == 0) dir = ~dir;
            if ($urandom_range(0, 9) == 0) period = CNT_W'($urandom_range(0, 10));
            fault_req = ($urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
